im_prefetch_unit: RTL

- Instruction-fetch sequencer in front of the instruction ROM. The ROM is combinational and has a 16-bit byte address and a 32-bit read word.
- Owns the fetch PC and drives the ROM address every cycle.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Flushes and restarts on redirects from branch, jump, trap or uret.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/im_pf_fifo.sv | 70 +++++++
 rtl/im_prefetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end constants and types used by the instruction-fetch path.
package rv32i_pkg;

  localparam int XLEN      = 32;
  localparam int IM_ADDR_W = 16;
  localparam int PC_STEP   = 4;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [IM_ADDR_W-1:0] pc;
    logic [XLEN-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/im_pf_fifo.sv
// Synchronous FIFO for the prefetch unit: flush beats push/pop, and a push
// into a full FIFO is only accepted when the head is popped in the same cycle.
module im_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rdata_o = mem_q[rdPtr_q];

  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/im_prefetch_unit.sv
// Instruction prefetch sequencer: owns the fetch PC, buffers {pc, word} pairs and
// restarts on redirects. Define IM_PREFETCH_BYPASS_EN to forward ROM data when empty.
import rv32i_pkg::*;

module im_prefetch_unit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = IM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [XLEN-1:0]   im_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int ENTRY_W = ADDR_W + XLEN;

  logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
  logic [ENTRY_W-1:0] headEntry;
  logic               fifoFull, fifoEmpty;
  logic               push, pop, advance;

  assign im_addr = fetchPc_q;

`ifdef IM_PREFETCH_BYPASS_EN
  logic bypassActive, bypassTake;

  // An empty FIFO exposes the live ROM word; a taken bypass word is never stored.
  assign bypassActive = fifoEmpty & ~redirect_valid & ~rst;
  assign bypassTake   = bypassActive & instr_ready;
  assign instr_valid  = ~fifoEmpty | bypassActive;
  assign pop          = ~fifoEmpty & instr_ready;
  assign push         = ~redirect_valid & (~fifoFull | pop) & ~bypassTake;
  assign advance      = push | bypassTake;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (bypassActive) begin
      instr    = im_rd;
      instr_pc = fetchPc_q;
    end else if (~fifoEmpty) begin
      {instr_pc, instr} = headEntry;
    end
  end
`else
  assign instr_valid = ~fifoEmpty;
  assign pop         = instr_valid & instr_ready;
  assign push        = ~redirect_valid & (~fifoFull | pop);
  assign advance     = push;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (~fifoEmpty) {instr_pc, instr} = headEntry;
  end
`endif

  // Redirect targets are word-aligned by clearing the two low address bits.
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (redirect_valid)
      fetchPc_d = redirect_pc & ~ADDR_W'(3);
    else if (advance)
      fetchPc_d = fetchPc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) fetchPc_q <= RESET_PC;
    else     fetchPc_q <= fetchPc_d;
  end

  im_pf_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) uFifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({fetchPc_q, im_rd}),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule
